// File: rtl/dp_ram_param.sv
// dp_ram_param: single-clock dual-port RAM with one write port and one read port.
// Supports per-byte write enables, read-first or write-first collision handling,
// an optional output register, and a clear sequencer that zeroes every word
// after reset before any request is accepted.
module dp_ram_param #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 5,
   parameter int DEPTH   = 16,
   parameter int WR_MODE = 0,
   parameter int OUT_REG = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enb,
   input  logic                wr,
   input  logic                rd,
   input  logic [ADDR_W-1:0]   w_addr,
   input  logic [ADDR_W-1:0]   r_addr,
   input  logic [DATA_W-1:0]   w_data,
   input  logic [DATA_W/8-1:0] w_be,
   output logic [DATA_W-1:0]   r_data,
   output logic                r_valid,
   output logic                init_busy,
   output logic                w_err,
   output logic                r_err
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Depth and last address sized to the address port so comparisons stay width-exact.
   localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                w_in_range;
   logic                r_in_range;
   logic                wr_acc;
   logic                rd_acc;
   logic                wr_commit;
   logic [IDX_W-1:0]    w_idx;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    ptr_idx;
   logic [DATA_W-1:0]   wr_merged;
   logic [DATA_W-1:0]   rd_word;

   logic [DATA_W-1:0]   s1_data;
   logic                s1_valid;
   logic                s1_err;

   // Sequencer state and clear pointer; the pointer only advances while clearing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= CLEAR;
         ptr     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) begin
            ptr <= ptr + 1'b1;
         end
      end
   end

   // Next state: leave CLEAR once the last word has been zeroed; busy while clearing.
   always_comb begin
      state_d   = state_q;
      init_busy = 1'b0;
      if (state_q == CLEAR) begin
         init_busy = 1'b1;
         if (ptr == LAST) begin
            state_d = RUN;
         end
      end
   end

   // Request decode, byte merge for writes, and read word selection with collision handling.
   always_comb begin
      w_in_range = ({1'b0, w_addr} < DEPTH_V);
      r_in_range = ({1'b0, r_addr} < DEPTH_V);
      wr_acc     = (state_q == RUN) && enb && wr;
      rd_acc     = (state_q == RUN) && enb && rd;
      wr_commit  = wr_acc && w_in_range;
      w_idx      = w_addr[IDX_W-1:0];
      r_idx      = r_addr[IDX_W-1:0];
      ptr_idx    = ptr[IDX_W-1:0];

      wr_merged = mem[w_idx];
      for (int k = 0; k < NB; k++) begin
         if (w_be[k]) begin
            wr_merged[8*k +: 8] = w_data[8*k +: 8];
         end
      end

      rd_word = '0;
      if (r_in_range) begin
         rd_word = mem[r_idx];
         if ((WR_MODE == 1) && wr_commit && (w_idx == r_idx)) begin
            rd_word = wr_merged;
         end
      end
   end

   // Memory array: zeroed word by word while clearing, merged writes while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         if (state_q == CLEAR) begin
            mem[ptr_idx] <= '0;
         end else if (wr_commit) begin
            mem[w_idx] <= wr_merged;
         end
      end
   end

   // First read stage and write error flag; data holds when no read is accepted.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         w_err    <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         s1_err   <= rd_acc && !r_in_range;
         w_err    <= wr_acc && !w_in_range;
         if (rd_acc) begin
            s1_data <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_W-1:0] s2_data;
         logic              s2_valid;
         logic              s2_err;

         // Optional second stage adds one cycle of read latency; flushed by reset.
         always_ff @(posedge clk) begin
            if (!rst) begin
               s2_data  <= '0;
               s2_valid <= 1'b0;
               s2_err   <= 1'b0;
            end else begin
               s2_valid <= s1_valid;
               s2_err   <= s1_err;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign r_data  = s2_data;
         assign r_valid = s2_valid;
         assign r_err   = s2_err;
      end else begin : g_no_out_reg
         assign r_data  = s1_data;
         assign r_valid = s1_valid;
         assign r_err   = s1_err;
      end
   endgenerate

endmodule

// File: tb/tb_dp_ram_param.sv
// tb_dp_ram_param: drives two RAM instances with identical stimulus.
// Instance a is read-first with latency 1, instance b is write-first with latency 2.
module tb_dp_ram_param;

   localparam int DW = 16;
   localparam int AW = 5;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enb = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [AW-1:0] w_addr = '0;
   logic [AW-1:0] r_addr = '0;
   logic [DW-1:0] w_data = '0;
   logic [1:0]    w_be = '0;

   logic [DW-1:0] a_rdata, b_rdata;
   logic          a_rvalid, b_rvalid, a_busy, b_busy;
   logic          a_werr, b_werr, a_rerr, b_rerr;

   int vectors = 0;
   int miscompares = 0;

   logic [DW-1:0] ra_data, ra_hold, rb_data;
   logic          ra_valid, ra_err, rb_valid, rb_err, rb_early;
   logic          wa_err, wb_err, wa_err2;

   dp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WR_MODE(0), .OUT_REG(0)) dut_a (
      .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd),
      .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .w_be(w_be),
      .r_data(a_rdata), .r_valid(a_rvalid), .init_busy(a_busy), .w_err(a_werr), .r_err(a_rerr)
   );

   dp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WR_MODE(1), .OUT_REG(1)) dut_b (
      .clk(clk), .rst(rst), .enb(enb), .wr(wr), .rd(rd),
      .w_addr(w_addr), .r_addr(r_addr), .w_data(w_data), .w_be(w_be),
      .r_data(b_rdata), .r_valid(b_rvalid), .init_busy(b_busy), .w_err(b_werr), .r_err(b_rerr)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Watchdog so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish before 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] be);
      @(negedge clk);
      enb = 1'b1; wr = 1'b1; rd = 1'b0; w_addr = addr; w_data = data; w_be = be;
      @(posedge clk); #1;
      wa_err = a_werr; wb_err = b_werr;
      @(negedge clk);
      wr = 1'b0;
      @(posedge clk); #1;
      wa_err2 = a_werr;
   endtask

   task automatic do_read(input logic [AW-1:0] addr);
      @(negedge clk);
      enb = 1'b1; rd = 1'b1; wr = 1'b0; r_addr = addr;
      @(posedge clk); #1;
      ra_data = a_rdata; ra_valid = a_rvalid; ra_err = a_rerr; rb_early = b_rvalid;
      @(negedge clk);
      rd = 1'b0;
      @(posedge clk); #1;
      ra_hold = a_rdata; rb_data = b_rdata; rb_valid = b_rvalid; rb_err = b_rerr;
   endtask

   task automatic do_wr_rd(input logic [AW-1:0] waddr, input logic [DW-1:0] data,
                           input logic [1:0] be, input logic [AW-1:0] raddr);
      @(negedge clk);
      enb = 1'b1; wr = 1'b1; rd = 1'b1; w_addr = waddr; w_data = data; w_be = be; r_addr = raddr;
      @(posedge clk); #1;
      ra_data = a_rdata; ra_valid = a_rvalid; wa_err = a_werr;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
      rb_data = b_rdata; rb_valid = b_rvalid;
   endtask

   task automatic wait_clear(input string tag);
      int cnt = 0;
      int stray = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
         stray += int'(a_rvalid) + int'(b_rvalid) + int'(a_werr) + int'(b_werr);
      end while (a_busy && cnt < 100);
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      vectors++; if (cnt !== 16) begin miscompares++; $display("[TB] FAIL %s_busy_cycles: got %0d expected 16", tag, cnt); end
      vectors++; if (b_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_b_busy_low: got %b expected 0", tag, b_busy); end
      vectors++; if (stray !== 0) begin miscompares++; $display("[TB] FAIL %s_no_pulses_in_clear: got %0d expected 0", tag, stray); end
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < DP; i++) begin
         do_read(AW'(i));
         vectors++; if (ra_valid !== 1'b1 || ra_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL %s_a_addr%0d: got valid=%b data=%h expected valid=1 data=0000", tag, i, ra_valid, ra_data); end
         vectors++; if (rb_valid !== 1'b1 || rb_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL %s_b_addr%0d: got valid=%b data=%h expected valid=1 data=0000", tag, i, rb_valid, rb_data); end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; enb = 1'b1; wr = 1'b1; rd = 1'b1;
      w_addr = 5'd2; w_data = 16'hFFFF; w_be = 2'b11; r_addr = 5'd20;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (a_rdata !== 16'h0000 || b_rdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_rdata: got a=%h b=%h expected 0000", a_rdata, b_rdata); end
      vectors++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got a=%b b=%b expected 0", a_rvalid, b_rvalid); end
      vectors++; if (a_busy !== 1'b1 || b_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got a=%b b=%b expected 1", a_busy, b_busy); end
      vectors++; if (a_werr !== 1'b0 || b_werr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_werr: got a=%b b=%b expected 0", a_werr, b_werr); end
      vectors++; if (a_rerr !== 1'b0 || b_rerr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rerr: got a=%b b=%b expected 0", a_rerr, b_rerr); end
      @(negedge clk);
      rst = 1'b1;
      wait_clear("release");
      read_all_zero("clear");
   endtask

   task automatic test_byte_enable();
      do_write(5'd3, 16'hABCD, 2'b11);
      vectors++; if (wa_err !== 1'b0) begin miscompares++; $display("[TB] FAIL be_werr_clean: got %b expected 0", wa_err); end
      do_write(5'd3, 16'h1234, 2'b01);
      do_write(5'd8, 16'hBEEF, 2'b00);
      do_read(5'd3);
      vectors++; if (ra_data !== 16'hAB34) begin miscompares++; $display("[TB] FAIL be_merge_a: got %h expected ab34", ra_data); end
      vectors++; if (rb_data !== 16'hAB34) begin miscompares++; $display("[TB] FAIL be_merge_b: got %h expected ab34", rb_data); end
      vectors++; if (ra_hold !== 16'hAB34) begin miscompares++; $display("[TB] FAIL be_hold_a: got %h expected ab34", ra_hold); end
      vectors++; if (rb_early !== 1'b0) begin miscompares++; $display("[TB] FAIL be_b_latency: got valid=%b one edge after request expected 0", rb_early); end
      vectors++; if (ra_err !== 1'b0 || rb_err !== 1'b0) begin miscompares++; $display("[TB] FAIL be_rerr_clean: got a=%b b=%b expected 0", ra_err, rb_err); end
      do_read(5'd8);
      vectors++; if (ra_data !== 16'h0000 || rb_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL be_zero_noop: got a=%h b=%h expected 0000", ra_data, rb_data); end
   endtask

   task automatic test_collision();
      do_write(5'd5, 16'h0011, 2'b11);
      do_wr_rd(5'd5, 16'h0022, 2'b11, 5'd5);
      vectors++; if (ra_valid !== 1'b1 || ra_data !== 16'h0011) begin miscompares++; $display("[TB] FAIL coll_read_first: got valid=%b data=%h expected 1 0011", ra_valid, ra_data); end
      vectors++; if (rb_valid !== 1'b1 || rb_data !== 16'h0022) begin miscompares++; $display("[TB] FAIL coll_write_first: got valid=%b data=%h expected 1 0022", rb_valid, rb_data); end
      do_read(5'd5);
      vectors++; if (ra_data !== 16'h0022 || rb_data !== 16'h0022) begin miscompares++; $display("[TB] FAIL coll_after: got a=%h b=%h expected 0022", ra_data, rb_data); end
      do_write(5'd6, 16'h1234, 2'b11);
      do_wr_rd(5'd6, 16'hABCD, 2'b10, 5'd6);
      vectors++; if (ra_data !== 16'h1234) begin miscompares++; $display("[TB] FAIL coll_partial_a: got %h expected 1234", ra_data); end
      vectors++; if (rb_data !== 16'hAB34) begin miscompares++; $display("[TB] FAIL coll_partial_b: got %h expected ab34", rb_data); end
      do_wr_rd(5'd7, 16'h7777, 2'b11, 5'd5);
      vectors++; if (ra_data !== 16'h0022 || rb_data !== 16'h0022) begin miscompares++; $display("[TB] FAIL diff_addr_read: got a=%h b=%h expected 0022", ra_data, rb_data); end
      do_read(5'd7);
      vectors++; if (ra_data !== 16'h7777 || rb_data !== 16'h7777) begin miscompares++; $display("[TB] FAIL diff_addr_write: got a=%h b=%h expected 7777", ra_data, rb_data); end
   endtask

   task automatic test_out_of_range();
      do_write(5'd4, 16'h5A5A, 2'b11);
      do_write(5'd20, 16'hFFFF, 2'b11);
      vectors++; if (wa_err !== 1'b1 || wb_err !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_werr: got a=%b b=%b expected 1", wa_err, wb_err); end
      vectors++; if (wa_err2 !== 1'b0) begin miscompares++; $display("[TB] FAIL oor_werr_pulse: got %b expected 0", wa_err2); end
      do_read(5'd4);
      vectors++; if (ra_data !== 16'h5A5A || rb_data !== 16'h5A5A) begin miscompares++; $display("[TB] FAIL oor_no_alias: got a=%h b=%h expected 5a5a", ra_data, rb_data); end
      do_read(5'd20);
      vectors++; if (ra_valid !== 1'b1 || ra_err !== 1'b1 || ra_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL oor_read_a: got v=%b e=%b d=%h expected 1 1 0000", ra_valid, ra_err, ra_data); end
      vectors++; if (rb_valid !== 1'b1 || rb_err !== 1'b1 || rb_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL oor_read_b: got v=%b e=%b d=%h expected 1 1 0000", rb_valid, rb_err, rb_data); end
   endtask

   task automatic test_back_to_back();
      logic slot_en [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic exp_v;
      for (int i = 0; i < 5; i++) begin
         do_write(AW'(i), DW'(16'hC000 + i), 2'b11);
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 5) begin rd = 1'b1; enb = slot_en[i]; r_addr = AW'(i); end
         else begin rd = 1'b0; enb = 1'b1; end
         @(posedge clk); #1;
         exp_v = 1'b0;
         if (i < 5) exp_v = slot_en[i];
         vectors++; if (a_rvalid !== exp_v) begin miscompares++; $display("[TB] FAIL stream_a_valid%0d: got %b expected %b", i, a_rvalid, exp_v); end
         if (exp_v) begin
            vectors++; if (a_rdata !== DW'(16'hC000 + i)) begin miscompares++; $display("[TB] FAIL stream_a_data%0d: got %h expected %h", i, a_rdata, DW'(16'hC000 + i)); end
         end
         exp_v = 1'b0;
         if (i >= 1 && i <= 5) exp_v = slot_en[i-1];
         vectors++; if (b_rvalid !== exp_v) begin miscompares++; $display("[TB] FAIL stream_b_valid%0d: got %b expected %b", i, b_rvalid, exp_v); end
         if (exp_v) begin
            vectors++; if (b_rdata !== DW'(16'hC000 + i - 1)) begin miscompares++; $display("[TB] FAIL stream_b_data%0d: got %h expected %h", i, b_rdata, DW'(16'hC000 + i - 1)); end
         end
      end
      @(negedge clk);
      enb = 1'b1; wr = 1'b1; w_addr = 5'd9; w_data = 16'h9999; w_be = 2'b11;
      @(negedge clk);
      wr = 1'b0; rd = 1'b1; r_addr = 5'd9;
      @(posedge clk); #1;
      vectors++; if (a_rdata !== 16'h9999) begin miscompares++; $display("[TB] FAIL wr_then_rd_a: got %h expected 9999", a_rdata); end
      @(negedge clk);
      rd = 1'b0;
      @(posedge clk); #1;
      vectors++; if (b_rdata !== 16'h9999) begin miscompares++; $display("[TB] FAIL wr_then_rd_b: got %h expected 9999", b_rdata); end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      enb = 1'b1; rd = 1'b1; r_addr = 5'd0;
      @(posedge clk); #1;
      @(negedge clk);
      rd = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (b_rvalid !== 1'b0 || a_rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_drop_valid: got a=%b b=%b expected 0", a_rvalid, b_rvalid); end
      vectors++; if (a_busy !== 1'b1 || b_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_busy: got a=%b b=%b expected 1", a_busy, b_busy); end
      vectors++; if (b_rdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_flush_b: got %h expected 0000", b_rdata); end
      @(negedge clk);
      rst = 1'b1;
      wait_clear("reclear");
      read_all_zero("reclear");
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_byte_enable();
      test_collision();
      test_out_of_range();
      test_back_to_back();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
